// File: rtl/regfile_sync.sv
// Two-read, one-write synchronous register file; word 0 reads as zero and read data is registered.
// Define REGFILE_BYPASS_EN for write-through on a same-edge read/write to one address.
module regfile_sync #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 5
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 RdEn,
    input  logic [ADDRWIDTH-1:0] Ardr1,
    input  logic [ADDRWIDTH-1:0] Ardr2,
    input  logic                 WrEn,
    input  logic [ADDRWIDTH-1:0] Awr,
    input  logic [DATAWIDTH-1:0] Din,
    output logic [DATAWIDTH-1:0] Dout1,
    output logic [DATAWIDTH-1:0] Dout2
);

    localparam int unsigned DEPTH = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DATAWIDTH-1:0] rd1;
    logic [DATAWIDTH-1:0] rd2;
    logic                 wr_ok;

    // Word 0 is never written, so it stays at its reset value of zero.
    assign wr_ok = WrEn && (Awr != '0);

    always_comb begin
        rd1 = mem[Ardr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (Awr == Ardr1)) rd1 = Din;
`endif
        if (Ardr1 == '0) rd1 = '0;
    end

    always_comb begin
        rd2 = mem[Ardr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (Awr == Ardr2)) rd2 = Din;
`endif
        if (Ardr2 == '0) rd2 = '0;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            mem   <= '{default: '0};
            Dout1 <= '0;
            Dout2 <= '0;
        end else begin
            if (wr_ok) mem[Awr] <= Din;
            if (RdEn) begin
                Dout1 <= rd1;
                Dout2 <= rd2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sync.sv
// Directed-vector bench for regfile_sync; expected values are hand-computed constants.
module tb_regfile_sync;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        RdEn;
    logic [4:0]  Ardr1;
    logic [4:0]  Ardr2;
    logic        WrEn;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic [31:0] Dout1;
    logic [31:0] Dout2;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    regfile_sync #(.DATAWIDTH(32), .ADDRWIDTH(5)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .RdEn   (RdEn),
        .Ardr1  (Ardr1),
        .Ardr2  (Ardr2),
        .WrEn   (WrEn),
        .Awr    (Awr),
        .Din    (Din),
        .Dout1  (Dout1),
        .Dout2  (Dout2)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WrEn = 1'b0; RdEn = 1'b0; Awr = '0; Din = '0; Ardr1 = '0; Ardr2 = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        WrEn = 1'b1; Awr = a; Din = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        idle();
        RdEn = 1'b1; Ardr1 = a1; Ardr2 = a2;
        tick();
        idle();
    endtask

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] hz;

        idle();
        Resetn = 1'b0;
        #12;
        check("reset_dout1", Dout1, 32'h0);
        check("reset_dout2", Dout2, 32'h0);
        Resetn = 1'b1;
        tick();

        // Asynchronous reset mid-cycle after word 7 holds data
        wr(5'd7, 32'hDEADBEEF);
        rd(5'd7, 5'd7);
        check("pre_reset_rd7", Dout1, 32'hDEADBEEF);
        #2;
        Resetn = 1'b0;
        #1;
        check("async_rst_dout1", Dout1, 32'h0);
        check("async_rst_dout2", Dout2, 32'h0);
        WrEn = 1'b1; Awr = 5'd7; Din = 32'h55AA55AA; RdEn = 1'b1; Ardr1 = 5'd7; Ardr2 = 5'd7;
        tick();
        check("rst_ignores_rd", Dout1, 32'h0);
        idle();
        Resetn = 1'b1;
        rd(5'd7, 5'd7);
        check("rst_cleared_w7_p1", Dout1, 32'h0);
        check("rst_cleared_w7_p2", Dout2, 32'h0);

        // Basic write then read on both ports
        wr(5'd3, 32'h12345678);
        rd(5'd3, 5'd3);
        check("basic_p1", Dout1, 32'h12345678);
        check("basic_p2", Dout2, 32'h12345678);

        // Zero register
        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd3);
        check("zero_p1", Dout1, 32'h0);
        check("zero_other_p2", Dout2, 32'h12345678);
        idle();
        WrEn = 1'b1; Awr = 5'd0; Din = 32'hFFFFFFFF; RdEn = 1'b1; Ardr1 = 5'd0; Ardr2 = 5'd0;
        tick();
        idle();
        check("zero_same_edge_p1", Dout1, 32'h0);
        check("zero_same_edge_p2", Dout2, 32'h0);

        // Same-edge read/write hazard; port 2 reads an untouched word
        wr(5'd5, 32'h00000011);
        idle();
        WrEn = 1'b1; Awr = 5'd5; Din = 32'h00000022; RdEn = 1'b1; Ardr1 = 5'd5; Ardr2 = 5'd6;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        hz = 32'h00000022;
`else
        hz = 32'h00000011;
`endif
        check("hazard_p1", Dout1, hz);
        check("hazard_p2_other", Dout2, 32'h0);
        rd(5'd6, 5'd5);
        check("hazard_next_p2", Dout2, 32'h00000022);
        check("hazard_next_p1", Dout1, 32'h0);

        // Hold outputs while RdEn is low, even when the read word is overwritten
        wr(5'd9, 32'hA5A5A5A5);
        rd(5'd9, 5'd3);
        check("hold_setup", Dout1, 32'hA5A5A5A5);
        for (int k = 0; k < 3; k++) begin
            idle();
            WrEn = 1'b1; Awr = 5'd9; Din = 32'h0; Ardr1 = 5'd9;
            tick();
            check($sformatf("hold_p1_%0d", k), Dout1, 32'hA5A5A5A5);
            check($sformatf("hold_p2_%0d", k), Dout2, 32'h12345678);
        end
        rd(5'd9, 5'd9);
        check("hold_after_p1", Dout1, 32'h0);

        // Sweep: word i = i * 0x01010101, read pairs (i, 31-i)
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            v1 = 32'(i) * 32'h01010101;
            v2 = 32'(31 - i) * 32'h01010101;
            check($sformatf("sweep_p1_%0d", i), Dout1, v1);
            check($sformatf("sweep_p2_%0d", i), Dout2, v2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sync.md
REGFILE_SYNC -- requirements
Module: regfile_sync

Interface
REQ-001 Parameter: DATAWIDTH, default 32, word width; feeds the downstream 32-bit operand selectors.
REQ-002 Parameter: ADDRWIDTH, default 5, address width; depth is 2**ADDRWIDTH words.
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: RdEn  input  1  read enable; samples both read ports on the edge when high.
REQ-006 Port: Ardr1  input  ADDRWIDTH  read address, port 1.
REQ-007 Port: Ardr2  input  ADDRWIDTH  read address, port 2.
REQ-008 Port: WrEn  input  1  write enable.
REQ-009 Port: Awr  input  ADDRWIDTH  write address.
REQ-010 Port: Din  input  DATAWIDTH  write data.
REQ-011 Port: Dout1  output  DATAWIDTH  registered read data, port 1.
REQ-012 Port: Dout2  output  DATAWIDTH  registered read data, port 2.

Function
REQ-013 Storage SHALL be 2**ADDRWIDTH words of DATAWIDTH bits; word 0 is hardwired zero.
REQ-014 Write: on rising edge with WrEn=1 and Awr!=0, word[Awr] SHALL take Din; WrEn=1 with Awr=0 SHALL change nothing.
REQ-015 Read latency SHALL be exactly 1 cycle: on rising edge with RdEn=1, Dout1<=word[Ardr1], Dout2<=word[Ardr2].
REQ-016 With RdEn=0, Dout1/Dout2 SHALL hold their previous values, regardless of writes.
REQ-017 Any read of address 0 SHALL return all zeros, including when a write to 0 occurs in the same cycle.
REQ-018 Ardr1==Ardr2 SHALL return identical data on both ports.
REQ-019 Read and write on the same edge to the same nonzero address: behaviour per REQ-024/REQ-025.
REQ-020 No X SHALL appear on Dout1/Dout2 after reset, for any address sequence.

Reset
REQ-021 Resetn=0 SHALL, asynchronously and without waiting for Clk, clear every storage word and Dout1/Dout2 to 0.
REQ-022 While Resetn=0, writes and reads SHALL be ignored.
REQ-023 A write coincident with reset assertion SHALL be lost; the first edge after Resetn rises SHALL operate normally.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN defined: same-edge read/write to the same nonzero address SHALL return Din (write-through), per port independently.
REQ-025 Macro REGFILE_BYPASS_EN undefined: that read SHALL return the pre-write (old) word; the new value is visible on the next read.

Verification
REQ-026 Reset: assert Resetn=0 mid-cycle after writing 0xDEADBEEF to word 7 -> Dout1/Dout2=0 immediately; later read of 7 -> 0x00000000.
REQ-027 Basic: write 0x12345678 to 3, next cycle RdEn=1, Ardr1=3, Ardr2=3 -> one edge later Dout1=Dout2=0x12345678.
REQ-028 Zero register: WrEn=1, Awr=0, Din=0xFFFFFFFF, then read 0 -> Dout1=0x00000000.
REQ-029 Same-edge hazard: word 5=0x00000011, then same edge WrEn=1, Awr=5, Din=0x00000022, RdEn=1, Ardr1=5 -> Dout1=0x00000022 with REGFILE_BYPASS_EN, 0x00000011 without; next read 0x00000022 in both builds.
REQ-030 Hold: Dout1=0xA5A5A5A5, RdEn=0 for 3 cycles while writing 0x0 to the read address -> Dout1 stays 0xA5A5A5A5.
REQ-031 Sweep: write word i=i*0x01010101 for i=1..31, read pairs (i, 31-i) -> each port matches expected; port for 0 reads 0.
